// File: rtl/sram_fetch_arbiter_if.sv
// sram_fetch_arbiter_if
// Requester-side bus of the SRAM fetch arbiter. The voice players sit on the
// master modport; the arbiter sits on the slave modport.
//   REQ       level read request, one bit per requester
//   REQ_ADDR  flattened addresses, requester i at [i*ADDR_W +: ADDR_W]
//   ACK       one-hot pulse, request accepted
//   RD_VALID  one-hot pulse, RD_DATA belongs to that requester
//   RD_DATA   last captured SRAM word, held until the next capture
//   BUSY      a read is in flight
interface sram_fetch_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        REQ;
  logic [NUM_REQ*ADDR_W-1:0] REQ_ADDR;
  logic [NUM_REQ-1:0]        ACK;
  logic [NUM_REQ-1:0]        RD_VALID;
  logic [DATA_W-1:0]         RD_DATA;
  logic                      BUSY;

  modport master (output REQ, REQ_ADDR, input ACK, RD_VALID, RD_DATA, BUSY);
  modport slave  (input REQ, REQ_ADDR, output ACK, RD_VALID, RD_DATA, BUSY);
endinterface

// File: rtl/sram_fetch_arbiter.sv
// sram_fetch_arbiter
// Shares one read-only SRAM between NUM_REQ instruction-fetch requesters.
// Round-robin arbitration, one read in flight at a time, fixed access wait of
// WAIT_CYCLES edges between driving SRAM_A and capturing SRAM_D.
// Ports:
//   CLK, RST_N      clock (rising edge), asynchronous active-low reset
//   bus             sram_fetch_arbiter_if.slave (REQ/REQ_ADDR in,
//                   ACK/RD_VALID/RD_DATA/BUSY out)
//   SRAM_A          registered SRAM address, holds its value while idle
//   SRAM_D          SRAM read data
//   SRAM_WE/CE/OE/LB/UB  fixed 1/0/0/0/0: read-only, both bytes enabled
// Optional build macro SRAM_FETCH_STATS_EN adds:
//   FETCH_CNT       saturating count of completed reads
//   MAX_WAIT        saturating maximum of cycles a requester held REQ before ACK
module sram_fetch_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                CLK,
  input  logic                RST_N,
  sram_fetch_arbiter_if.slave bus,
  output logic [ADDR_W-1:0]   SRAM_A,
  input  logic [DATA_W-1:0]   SRAM_D,
  output logic                SRAM_WE,
  output logic                SRAM_CE,
  output logic                SRAM_OE,
  output logic                SRAM_LB,
  output logic                SRAM_UB
`ifdef SRAM_FETCH_STATS_EN
  ,
  output logic [15:0]         FETCH_CNT,
  output logic [15:0]         MAX_WAIT
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  state_t             state_q, state_n;
  logic [NUM_REQ-1:0] ack_q, ack_n;
  logic [NUM_REQ-1:0] rd_valid_q, rd_valid_n;
  logic [DATA_W-1:0]  rd_data_q, rd_data_n;
  logic [ADDR_W-1:0]  sram_a_q, sram_a_n;
  logic [CNT_W-1:0]   cnt_q, cnt_n;
  logic [IDX_W-1:0]   last_q, last_n;
  logic               any_req;
  logic [IDX_W-1:0]   grant_idx;
  logic [IDX_W-1:0]   probe_idx;

  // Rotating-priority search: start one past the last winner and take the
  // first requester found, so every waiting requester is reached within
  // NUM_REQ grants.
  always_comb begin
    any_req   = 1'b0;
    grant_idx = last_q;
    probe_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      probe_idx = IDX_W'((int'(last_q) + k) % NUM_REQ);
      if (!any_req && bus.REQ[probe_idx]) begin
        any_req   = 1'b1;
        grant_idx = probe_idx;
      end
    end
  end

  // State and output registers. Everything the requesters see is registered,
  // so ACK and RD_VALID are clean single-cycle pulses.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= ST_IDLE;
      ack_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
      sram_a_q   <= '0;
      cnt_q      <= '0;
      last_q     <= IDX_W'(NUM_REQ - 1);
    end else begin
      state_q    <= state_n;
      ack_q      <= ack_n;
      rd_valid_q <= rd_valid_n;
      rd_data_q  <= rd_data_n;
      sram_a_q   <= sram_a_n;
      cnt_q      <= cnt_n;
      last_q     <= last_n;
    end
  end

  // Next-state logic. IDLE launches a read for the arbitration winner; WAIT
  // counts access edges and captures SRAM_D on the last one. The winner index
  // stays in last_q for the whole read, so it also steers RD_VALID.
  always_comb begin
    state_n    = state_q;
    ack_n      = '0;
    rd_valid_n = '0;
    rd_data_n  = rd_data_q;
    sram_a_n   = sram_a_q;
    cnt_n      = cnt_q;
    last_n     = last_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          sram_a_n         = bus.REQ_ADDR[grant_idx*ADDR_W +: ADDR_W];
          ack_n[grant_idx] = 1'b1;
          last_n           = grant_idx;
          cnt_n            = '0;
          state_n          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(WAIT_CYCLES - 1)) begin
          rd_data_n          = SRAM_D;
          rd_valid_n[last_q] = 1'b1;
          state_n            = ST_IDLE;
        end else begin
          cnt_n = cnt_q + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign bus.ACK      = ack_q;
  assign bus.RD_VALID = rd_valid_q;
  assign bus.RD_DATA  = rd_data_q;
  assign bus.BUSY     = (state_q == ST_WAIT);
  assign SRAM_A       = sram_a_q;
  assign SRAM_WE      = 1'b1;
  assign SRAM_CE      = 1'b0;
  assign SRAM_OE      = 1'b0;
  assign SRAM_LB      = 1'b0;
  assign SRAM_UB      = 1'b0;

`ifdef SRAM_FETCH_STATS_EN
  logic [15:0] fetch_cnt_q;
  logic [15:0] max_wait_q;
  logic [15:0] wait_q [NUM_REQ];

  // Per-requester wait counters count edges where REQ was high but another
  // requester (or nobody, while busy) was served. On the granting edge the
  // counter is folded into the running maximum and cleared.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      fetch_cnt_q <= '0;
      max_wait_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) wait_q[i] <= '0;
    end else begin
      if (|rd_valid_n && fetch_cnt_q != 16'hFFFF) fetch_cnt_q <= fetch_cnt_q + 16'd1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (ack_n[i]) begin
          if (wait_q[i] > max_wait_q) max_wait_q <= wait_q[i];
          wait_q[i] <= '0;
        end else if (bus.REQ[i]) begin
          if (wait_q[i] != 16'hFFFF) wait_q[i] <= wait_q[i] + 16'd1;
        end else begin
          wait_q[i] <= '0;
        end
      end
    end
  end

  assign FETCH_CNT = fetch_cnt_q;
  assign MAX_WAIT  = max_wait_q;
`endif

endmodule

// File: tb/tb_sram_fetch_arbiter.sv
// tb_sram_fetch_arbiter
// Scenario tasks drive the requesters and push the ACK/RD_VALID events they
// expect (cycle, one-hot, address or data) into queues; a monitor records what
// the DUT actually produced and test_scoreboard pairs the two lists at the end.
module tb_sram_fetch_arbiter;
  localparam int NUM_REQ     = 4;
  localparam int ADDR_W      = 18;
  localparam int DATA_W      = 16;
  localparam int WAIT_CYCLES = 2;

  typedef struct packed {
    int                 cyc;
    logic [NUM_REQ-1:0] onehot;
    logic [31:0]        val;
  } event_t;

  logic               CLK = 1'b0;
  logic               RST_N = 1'b0;
  logic [NUM_REQ-1:0] req;
  logic [ADDR_W-1:0]  addr [NUM_REQ];
  logic [ADDR_W-1:0]  sram_a;
  logic [DATA_W-1:0]  sram_d;
  logic               sram_we, sram_ce, sram_oe, sram_lb, sram_ub;
`ifdef SRAM_FETCH_STATS_EN
  logic [15:0]        fetch_cnt, max_wait;
`endif

  int     vectors = 0;
  int     miscompares = 0;
  int     cyc = 0;
  event_t exp_ack[$], exp_rd[$], obs_ack[$], obs_rd[$];

  sram_fetch_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_fetch_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_CYCLES(WAIT_CYCLES)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .bus(bus),
    .SRAM_A(sram_a), .SRAM_D(sram_d),
    .SRAM_WE(sram_we), .SRAM_CE(sram_ce), .SRAM_OE(sram_oe),
    .SRAM_LB(sram_lb), .SRAM_UB(sram_ub)
`ifdef SRAM_FETCH_STATS_EN
    , .FETCH_CNT(fetch_cnt), .MAX_WAIT(max_wait)
`endif
  );

  assign bus.REQ      = req;
  assign bus.REQ_ADDR = {addr[3], addr[2], addr[1], addr[0]};
  // SRAM contents: word = low address bits XOR 16'h8A30
  assign sram_d       = sram_a[15:0] ^ 16'h8A30;

  // 50 MHz clock
  always #10 CLK = ~CLK;

  // Count rising edges so events can be stamped with the edge that made them
  always @(posedge CLK) cyc <= cyc + 1;

  // Record every ACK and RD_VALID pulse, sampled mid-cycle
  always @(negedge CLK) begin
    if (bus.ACK != '0) obs_ack.push_back(event_t'{cyc, bus.ACK, 32'(sram_a)});
    if (bus.RD_VALID != '0) obs_rd.push_back(event_t'{cyc, bus.RD_VALID, 32'(bus.RD_DATA)});
  end

  function automatic logic [31:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'(a[15:0] ^ 16'h8A30);
  endfunction

  // Grant on edge c means ACK after edge c and RD_VALID after edge c+WAIT_CYCLES
  task automatic expect_read(input int c, input int idx, input logic [ADDR_W-1:0] a);
    exp_ack.push_back(event_t'{c, NUM_REQ'(1) << idx, 32'(a)});
    exp_rd.push_back(event_t'{c + WAIT_CYCLES, NUM_REQ'(1) << idx, mem_word(a)});
  endtask

  task automatic pulse_reset();
    @(negedge CLK); RST_N = 1'b0;
    @(negedge CLK); RST_N = 1'b1;
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) addr[i] = '0;
    repeat (2) @(negedge CLK);
    vectors++; if (bus.ACK !== '0) begin miscompares++; $display("[TB] FAIL reset_ack: got %b expected 0000", bus.ACK); end
    vectors++; if (bus.RD_VALID !== '0) begin miscompares++; $display("[TB] FAIL reset_rd_valid: got %b expected 0000", bus.RD_VALID); end
    vectors++; if (bus.RD_DATA !== '0) begin miscompares++; $display("[TB] FAIL reset_rd_data: got %h expected 0000", bus.RD_DATA); end
    vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 0", bus.BUSY); end
    vectors++; if (sram_a !== '0) begin miscompares++; $display("[TB] FAIL reset_sram_a: got %h expected 00000", sram_a); end
    vectors++;
    if ({sram_we, sram_ce, sram_oe, sram_lb, sram_ub} !== 5'b10000) begin
      miscompares++;
      $display("[TB] FAIL sram_ctrl: got %b expected 10000", {sram_we, sram_ce, sram_oe, sram_lb, sram_ub});
    end
    RST_N = 1'b1;
  endtask

  task automatic test_single_read();
    int c;
    @(negedge CLK);
    c = cyc;
    addr[0] = 18'h00005;
    req = 4'b0001;
    expect_read(c + 1, 0, 18'h00005);
    @(negedge CLK);
    req = '0;
    vectors++; if (bus.ACK !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_ack: got %b expected 0001", bus.ACK); end
    vectors++; if (sram_a !== 18'h00005) begin miscompares++; $display("[TB] FAIL single_sram_a: got %h expected 00005", sram_a); end
    vectors++; if (bus.BUSY !== 1'b1) begin miscompares++; $display("[TB] FAIL single_busy: got %b expected 1", bus.BUSY); end
    repeat (2) @(negedge CLK);
    vectors++; if (bus.RD_VALID !== 4'b0001) begin miscompares++; $display("[TB] FAIL single_rd_valid: got %b expected 0001", bus.RD_VALID); end
    vectors++; if (bus.RD_DATA !== 16'h8A35) begin miscompares++; $display("[TB] FAIL single_rd_data: got %h expected 8a35", bus.RD_DATA); end
    @(negedge CLK);
    vectors++; if (bus.RD_VALID !== '0) begin miscompares++; $display("[TB] FAIL single_rd_valid_clear: got %b expected 0000", bus.RD_VALID); end
    vectors++; if (bus.RD_DATA !== 16'h8A35) begin miscompares++; $display("[TB] FAIL single_rd_data_hold: got %h expected 8a35", bus.RD_DATA); end
  endtask

  task automatic test_round_robin();
    int c;
    pulse_reset();
    for (int i = 0; i < NUM_REQ; i++) addr[i] = ADDR_W'(18'h10100 + i * 18'h00111);
    @(negedge CLK);
    c = cyc;
    req = 4'b1111;
    for (int k = 0; k < 8; k++) expect_read(c + 1 + 3 * k, k % NUM_REQ, addr[k % NUM_REQ]);
    repeat (22) @(negedge CLK);
    req = '0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_rotation_skip();
    int c;
    addr[0] = 18'h00A00; addr[1] = 18'h00A11; addr[3] = 18'h00A33;
    @(negedge CLK);
    c = cyc;
    req = 4'b0010;
    expect_read(c + 1, 1, addr[1]);
    @(negedge CLK);
    req = '0;
    repeat (2) @(negedge CLK);
    c = cyc;
    req = 4'b1001;
    expect_read(c + 1, 3, addr[3]);
    expect_read(c + 4, 0, addr[0]);
    @(negedge CLK);
    vectors++; if (bus.ACK !== 4'b1000) begin miscompares++; $display("[TB] FAIL skip_first: got %b expected 1000", bus.ACK); end
    req = 4'b0001;
    repeat (3) @(negedge CLK);
    vectors++; if (bus.ACK !== 4'b0001) begin miscompares++; $display("[TB] FAIL skip_second: got %b expected 0001", bus.ACK); end
    req = '0;
    repeat (3) @(negedge CLK);
  endtask

  task automatic test_withdraw();
    int c;
    addr[0] = 18'h02222; addr[2] = 18'h03333;
    @(negedge CLK);
    c = cyc;
    req = 4'b0001;
    expect_read(c + 1, 0, addr[0]);
    @(negedge CLK);
    req = 4'b0100;
    @(negedge CLK);
    req = '0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      vectors++; if (bus.ACK[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL withdraw_ack2: got %b expected 0", bus.ACK[2]); end
      vectors++; if (bus.RD_VALID[2] !== 1'b0) begin miscompares++; $display("[TB] FAIL withdraw_rd2: got %b expected 0", bus.RD_VALID[2]); end
    end
  endtask

  task automatic test_back_to_back();
    int c;
    addr[2] = 18'h31234;
    @(negedge CLK);
    c = cyc;
    req = 4'b0100;
    expect_read(c + 1, 2, 18'h31234);
    @(negedge CLK);
    addr[2] = 18'h20ABC;
    vectors++; if (sram_a !== 18'h31234) begin miscompares++; $display("[TB] FAIL b2b_addr_hold: got %h expected 31234", sram_a); end
    @(negedge CLK);
    vectors++; if (sram_a !== 18'h31234) begin miscompares++; $display("[TB] FAIL b2b_addr_ignored: got %h expected 31234", sram_a); end
    expect_read(c + 4, 2, 18'h20ABC);
    repeat (2) @(negedge CLK);
    req = '0;
    vectors++; if (bus.ACK !== 4'b0100) begin miscompares++; $display("[TB] FAIL b2b_regrant: got %b expected 0100", bus.ACK); end
    repeat (3) @(negedge CLK);
    vectors++; if (sram_a !== 18'h20ABC) begin miscompares++; $display("[TB] FAIL b2b_idle_hold: got %h expected 20abc", sram_a); end
    vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_busy: got %b expected 0", bus.BUSY); end
  endtask

  task automatic test_reset_mid_read();
    int c;
    addr[0] = 18'h12345; addr[1] = 18'h04444;
    @(negedge CLK);
    c = cyc;
    req = 4'b0001;
    exp_ack.push_back(event_t'{c + 1, 4'b0001, 32'(addr[0])});
    @(negedge CLK);
    req = '0;
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    vectors++; if (bus.BUSY !== 1'b0) begin miscompares++; $display("[TB] FAIL midrst_busy: got %b expected 0", bus.BUSY); end
    vectors++; if (sram_a !== '0) begin miscompares++; $display("[TB] FAIL midrst_sram_a: got %h expected 00000", sram_a); end
    vectors++; if (bus.RD_DATA !== '0) begin miscompares++; $display("[TB] FAIL midrst_rd_data: got %h expected 0000", bus.RD_DATA); end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    c = cyc;
    req = 4'b0010;
    expect_read(c + 1, 1, addr[1]);
    @(negedge CLK);
    req = '0;
    vectors++; if (bus.ACK !== 4'b0010) begin miscompares++; $display("[TB] FAIL midrst_after_ack: got %b expected 0010", bus.ACK); end
    repeat (3) @(negedge CLK);
  endtask

`ifdef SRAM_FETCH_STATS_EN
  task automatic test_stats();
    int c;
    pulse_reset();
    vectors++; if (fetch_cnt !== 16'd0) begin miscompares++; $display("[TB] FAIL stats_cnt_reset: got %0d expected 0", fetch_cnt); end
    for (int i = 0; i < NUM_REQ; i++) addr[i] = ADDR_W'(18'h05000 + i);
    @(negedge CLK);
    c = cyc;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) expect_read(c + 1 + 3 * k, k, addr[k]);
    repeat (10) @(negedge CLK);
    req = '0;
    repeat (2) @(negedge CLK);
    c = cyc;
    req = 4'b0001;
    expect_read(c + 1, 0, addr[0]);
    @(negedge CLK);
    req = '0;
    repeat (3) @(negedge CLK);
    vectors++; if (fetch_cnt !== 16'd5) begin miscompares++; $display("[TB] FAIL stats_fetch_cnt: got %0d expected 5", fetch_cnt); end
    vectors++; if (max_wait !== 16'd9) begin miscompares++; $display("[TB] FAIL stats_max_wait: got %0d expected 9", max_wait); end
  endtask
`endif

  task automatic test_scoreboard();
    int     n;
    event_t e, o;
    n = 0;
    while (exp_ack.size() > 0) begin
      e = exp_ack.pop_front();
      vectors++;
      if (n >= obs_ack.size()) begin
        miscompares++;
        $display("[TB] FAIL sb_ack_missing: got none, expected cyc=%0d ack=%b addr=%h", e.cyc, e.onehot, e.val);
      end else begin
        o = obs_ack[n];
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL sb_ack: got cyc=%0d ack=%b addr=%h, expected cyc=%0d ack=%b addr=%h",
                   o.cyc, o.onehot, o.val, e.cyc, e.onehot, e.val);
        end
      end
      n++;
    end
    vectors++;
    if (obs_ack.size() != n) begin miscompares++; $display("[TB] FAIL sb_ack_count: got %0d expected %0d", obs_ack.size(), n); end
    n = 0;
    while (exp_rd.size() > 0) begin
      e = exp_rd.pop_front();
      vectors++;
      if (n >= obs_rd.size()) begin
        miscompares++;
        $display("[TB] FAIL sb_rd_missing: got none, expected cyc=%0d rd_valid=%b data=%h", e.cyc, e.onehot, e.val);
      end else begin
        o = obs_rd[n];
        if (o !== e) begin
          miscompares++;
          $display("[TB] FAIL sb_rd: got cyc=%0d rd_valid=%b data=%h, expected cyc=%0d rd_valid=%b data=%h",
                   o.cyc, o.onehot, o.val, e.cyc, e.onehot, e.val);
        end
      end
      n++;
    end
    vectors++;
    if (obs_rd.size() != n) begin miscompares++; $display("[TB] FAIL sb_rd_count: got %0d expected %0d", obs_rd.size(), n); end
  endtask

  initial begin
    $display("[TB] sram_fetch_arbiter bench start");
    test_reset();
    test_single_read();
    test_round_robin();
    test_rotation_skip();
    test_withdraw();
    test_back_to_back();
    test_reset_mid_read();
`ifdef SRAM_FETCH_STATS_EN
    test_stats();
`endif
    test_scoreboard();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sram_fetch_arbiter.md
Name: sram_fetch_arbiter

Overview:
- Shares the single read-only SRAM between NUM_REQ instruction-fetch requesters, e.g. multiple voice/note players each fetching its next 16-bit instruction word.
- Round-robin arbitration; one outstanding SRAM read at a time; fixed, parameterised access wait.
- Sits between the voice players and the board SRAM pins, replacing per-player direct SRAM address driving.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 18, SRAM address width.
- DATA_W, 16, SRAM data width.
- WAIT_CYCLES, 2, clock edges from address drive to data capture (>=1).

Ports:
- CLK  in  1  system clock, 50 MHz, rising edge.
- RST_N  in  1  reset; asynchronous, active-low.
- REQ  in  NUM_REQ  per-requester read request, level.
- REQ_ADDR  in  NUM_REQ*ADDR_W  flattened addresses; requester i at bits [i*ADDR_W +: ADDR_W].
- ACK  out  NUM_REQ  one-hot, one-cycle pulse: request accepted.
- RD_VALID  out  NUM_REQ  one-hot, one-cycle pulse: RD_DATA belongs to requester i.
- RD_DATA  out  DATA_W  captured SRAM word; held until next capture.
- BUSY  out  1  high while a read is in flight (state WAIT).
- SRAM_A  out  ADDR_W  SRAM address, registered.
- SRAM_D  in  DATA_W  SRAM read data.
- SRAM_WE, SRAM_CE, SRAM_OE, SRAM_LB, SRAM_UB  out  1 each  constant 1,0,0,0,0 (read-only, both bytes).

Behaviour:
- Reset (async, RST_N=0): state IDLE; ACK=0, RD_VALID=0, RD_DATA=0, SRAM_A=0, BUSY=0, wait counter=0, last-grant pointer=NUM_REQ-1 so requester 0 wins first.
- FSM states: IDLE, WAIT.
- IDLE, edge with any REQ high:
  - Pick the first requester set in REQ, searching from (last+1) mod NUM_REQ upward with wrap.
  - SRAM_A <= that requester's address; ACK[g] <= 1; last <= g; cnt <= 0; state <= WAIT.
- IDLE, no REQ: stay; ACK=0.
- WAIT, each edge:
  - ACK <= 0.
  - If cnt == WAIT_CYCLES-1: RD_DATA <= SRAM_D; RD_VALID[g] <= 1; state <= IDLE.
  - Else cnt <= cnt+1.
- RD_VALID clears on the next edge.
- Latency, REQ sampled at edge E0:
  - ACK high after E0.
  - RD_VALID high after E0+WAIT_CYCLES.
  - WAIT_CYCLES=2: RD_VALID two cycles after ACK.
- Throughput: one read per WAIT_CYCLES+1 cycles. The arbiter may grant again on the edge where RD_VALID is high, since the state is already IDLE.
- Handshake:
  - Requester holds REQ and REQ_ADDR stable until its ACK.
  - Requester drops REQ on or after ACK unless it wants another read.
  - REQ still high in the RD_VALID cycle counts as a new request.
  - REQ dropped before ACK: request withdrawn, no response.
  - REQ dropped after ACK: read completes and RD_VALID still pulses.
  - REQ_ADDR changes after ACK are ignored.
- Round-robin fairness: with all REQ held high, grant order is 0,1,2,3,0,... Any waiting requester is served within NUM_REQ grants.
- Simultaneous events: multiple REQ in IDLE are resolved by the rotating priority only. REQ rising during WAIT is evaluated at the next IDLE edge.
- SRAM_A holds its last value in IDLE (no spurious toggling).
- Reset mid-WAIT: transaction aborted; no RD_VALID; requesters re-request after reset.
- Only one bit of ACK and one bit of RD_VALID is ever high, never both in the same cycle for WAIT_CYCLES>=1.

Optional Feature:
- Macro: SRAM_FETCH_STATS_EN.
- Defined:
  - Adds output FETCH_CNT [15:0], a count of completed reads (RD_VALID pulses), saturating at 16'hFFFF.
  - Adds output MAX_WAIT [15:0], the largest number of cycles any requester held REQ before ACK, saturating.
  - Both cleared by RST_N.
- Undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Single read: WAIT_CYCLES=2, REQ=0001, addr0=18'h00005, SRAM_D model returns 16'h8A35 -> ACK=0001 one cycle after the REQ edge; RD_VALID=0001 and RD_DATA=16'h8A35 two cycles later; SRAM_A=18'h00005.
- Round robin: REQ=1111 held for 8 grants -> ACK sequence 0,1,2,3,0,1,2,3; each grant 3 cycles apart.
- Rotation skip: last grant=1, REQ=1001 -> requester 3 granted before 0; next grant goes to 0.
- Withdraw: REQ[2] pulsed while requester 0 is in WAIT, dropped before IDLE -> no ACK[2], no RD_VALID[2].
- Reset mid-read: RST_N low one cycle after ACK -> outputs 0 immediately, no RD_VALID; after release REQ=0010 -> requester 1 served normally.
- Stats (SRAM_FETCH_STATS_EN): 5 completed reads -> FETCH_CNT=5; requester 3 waits 9 cycles behind others -> MAX_WAIT=9.
